// File: rtl/coreaxi4sram_rdwr_arb.sv
// Single-port SRAM arbiter: grants the shared port to one AXI4 burst at a time
// and produces the address-channel accept strobes for the slave interface.
module coreaxi4sram_rdwr_arb #(
  parameter int ARB_MODE = 0
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       AWVALID_slvif,
  input  logic [7:0] AWLEN_S,
  input  logic       ARVALID_slvif,
  input  logic [7:0] ARLEN_S,
  input  logic       wbeat,
  input  logic       WLAST_slvif,
  input  logic       bhs,
  input  logic       rbeat,
  output logic       awready_mc,
  output logic       waddrchset_mc,
  output logic       arready_mc,
  output logic       raddrchset_mc,
  output logic       wr_gnt,
  output logic       rd_gnt,
  output logic       rd_last,
  output logic       wlast_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] beat_cnt;
  logic       last_wr;
  logic       cnt_zero;

  assign cnt_zero = (beat_cnt == 8'd0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // On a tie, round-robin gives the port to the direction that did not go last.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (AWVALID_slvif && ARVALID_slvif) begin
          next_state = ((ARB_MODE == 1) || !last_wr) ? WR_ADDR : RD_ADDR;
        end else if (AWVALID_slvif) begin
          next_state = WR_ADDR;
        end else if (ARVALID_slvif) begin
          next_state = RD_ADDR;
        end
      end
      WR_ADDR: next_state = WR_DATA;
      WR_DATA: if (wbeat && cnt_zero) next_state = WR_RESP;
      WR_RESP: if (bhs) next_state = IDLE;
      RD_ADDR: next_state = RD_DATA;
      RD_DATA: if (rbeat && cnt_zero) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_cnt  <= 8'd0;
      last_wr   <= 1'b0;
      wlast_err <= 1'b0;
    end else begin
      case (state)
        WR_ADDR: beat_cnt <= AWLEN_S;
        RD_ADDR: beat_cnt <= ARLEN_S;
        WR_DATA: begin
          if (wbeat) begin
            if (!cnt_zero) beat_cnt <= beat_cnt - 8'd1;
            if (WLAST_slvif != cnt_zero) wlast_err <= 1'b1;
          end
        end
        WR_RESP: if (bhs) last_wr <= 1'b1;
        RD_DATA: begin
          if (rbeat) begin
            if (cnt_zero) last_wr <= 1'b0;
            else beat_cnt <= beat_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so no input-to-output combinational path.
  always_comb begin
    awready_mc    = (state == WR_ADDR);
    waddrchset_mc = (state == WR_ADDR);
    arready_mc    = (state == RD_ADDR);
    raddrchset_mc = (state == RD_ADDR);
    wr_gnt        = (state == WR_DATA) || (state == WR_RESP);
    rd_gnt        = (state == RD_DATA);
    rd_last       = (state == RD_DATA) && cnt_zero;
  end

endmodule

// File: doc/coreaxi4sram_rdwr_arb.md
# coreaxi4sram_rdwr_arb

Single-port SRAM access arbiter for the CoreAXI4SRAM core. Sits between the slave interface and the main control read/write datapaths. Grants the one shared SRAM port to exactly one AXI4 burst at a time and generates the address-channel accept strobes (`awready_mc`/`waddrchset_mc`, `arready_mc`/`raddrchset_mc`) consumed by the slave interface. Tracks burst beats so that the grant is released only at burst completion.

## Interface
Parameters:
- `ARB_MODE`, 0: 0 = round-robin between write and read; 1 = fixed write priority.

Ports:
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  reset, asynchronous, active-low.
- `AWVALID_slvif`  in  1  write address valid.
- `AWLEN_S`  in  8  write burst length minus 1.
- `ARVALID_slvif`  in  1  read address valid.
- `ARLEN_S`  in  8  read burst length minus 1.
- `wbeat`  in  1  write data handshake (WVALID & WREADY) this cycle.
- `WLAST_slvif`  in  1  WLAST qualifying `wbeat`.
- `bhs`  in  1  write response handshake (BVALID & BREADY).
- `rbeat`  in  1  read data handshake (RVALID & RREADY).
- `awready_mc`  out  1  write address accept; 1-cycle pulse.
- `waddrchset_mc`  out  1  latch AW fields; identical to `awready_mc`.
- `arready_mc`  out  1  read address accept; 1-cycle pulse.
- `raddrchset_mc`  out  1  latch AR fields; identical to `arready_mc`.
- `wr_gnt`  out  1  SRAM port owned by write burst (data phase).
- `rd_gnt`  out  1  SRAM port owned by read burst (data phase).
- `rd_last`  out  1  current read beat is the final one.
- `wlast_err`  out  1  sticky: WLAST mismatch with AWLEN.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA. 3-bit encoding; IDLE on reset.
- IDLE: arbitration uses the valids only.
  - Write only -> WR_ADDR.
  - Read only -> RD_ADDR.
  - Both valid, `ARB_MODE`=1 -> WR_ADDR.
  - Both valid, `ARB_MODE`=0 -> opposite of `last_wr` (1 = last grant was write; reset value 0, so the first tie goes to write).
- WR_ADDR (1 cycle): `awready_mc`=`waddrchset_mc`=1; `beat_cnt` <= `AWLEN_S`; -> WR_DATA.
- WR_DATA: `wr_gnt`=1. On `wbeat`:
  - `beat_cnt`==0 -> WR_RESP.
  - Otherwise decrement `beat_cnt`.
  - Any `wbeat` where `WLAST_slvif` != (`beat_cnt`==0) sets `wlast_err`. Beat counting continues regardless of WLAST.
- WR_RESP: `wr_gnt`=1. On `bhs`: `last_wr` <= 1; -> IDLE.
- RD_ADDR (1 cycle): `arready_mc`=`raddrchset_mc`=1; `beat_cnt` <= `ARLEN_S`; -> RD_DATA.
- RD_DATA: `rd_gnt`=1; `rd_last` = (`beat_cnt`==0). On `rbeat`:
  - `beat_cnt`==0 -> IDLE; `last_wr` <= 0.
  - Otherwise decrement `beat_cnt`.
- `beat_cnt`: 8 bits, shared by both directions (only one burst is active). A 256-beat burst loads 255; no wrap-around is possible.
- `wbeat` outside WR_DATA and `rbeat` outside RD_DATA are ignored.
- `bhs` outside WR_RESP is ignored.
- `wlast_err` is cleared only by reset.

## Timing
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Reset values: all outputs 0; `beat_cnt`=0; `last_wr`=0; state IDLE.
- Address latency: valid seen in IDLE at cycle n -> ready/chset pulse at n+1 -> grant from n+2.
- Turnaround: the burst-end cycle returns to IDLE, and the next grant is evaluated in IDLE. Minimum gap between the last data/B handshake and the next accept pulse is 2 cycles.
- A valid that deasserts before its accept pulse is still accepted. Masters must hold valid, per AXI4.
- Simultaneous `wbeat` and `bhs` in WR_DATA: `bhs` is ignored.
- ARESETN assertion mid-burst: state immediately returns to IDLE and the grant drops asynchronously. The interrupted burst is not resumed.

## Test plan
- Single write, `AWLEN_S`=3: AWVALID at cycle 0 -> `awready_mc`/`waddrchset_mc` high at cycle 1 only, `wr_gnt` from cycle 2. Drive 4 `wbeat` with WLAST on the 4th, then `bhs` -> IDLE the next cycle; `wlast_err`=0.
- Read, `ARLEN_S`=0: `arready_mc` pulse at cycle 1. `rd_last`=1 from cycle 2; after one `rbeat` -> `rd_gnt`=0 the next cycle.
- Tie, `ARB_MODE`=0, both valids held, all bursts `LEN`=1: grant order write, read, write, read. With `ARB_MODE`=1: write every time.
- `AWLEN_S`=255: 256 beats -> grant held until the 256th `wbeat` plus `bhs`; `beat_cnt` reaches 0 without wrap.
- WLAST on beat 2 of a 4-beat burst -> `wlast_err`=1 and stays 1. The burst still ends after 4 beats.
- ARESETN low during RD_DATA with `beat_cnt`=5 -> all outputs 0 immediately. After release, a new AR is accepted with `ARLEN` reloaded.
